mmio_uart_responder: RTL and testbench
======================================

Name: mmio_uart_responder

Overview:
- Memory-mapped peripheral that answers the core's data-memory bus (write enable, read enable, 9-bit address, write data, read data) inside a fixed address window.
- Contains a byte TX FIFO, a UART serializer, a writable baud divisor and a free-running 32-bit cycle counter.
- Sits beside the data memory. The top level selects this block's read data when hit is high.
- Gives programs running on the core a console output and a timer.

Parameters:
- DATA_W, 32, bus data width
- DM_ADDRESS, 9, bus byte-address width
- BASE_HI, 5'h1F, value of addr[8:4] that selects this block (window 0x1F0-0x1FF)
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, at least 2
- DEFAULT_DIV, 16'd16, reset value of the divisor register, in clocks per UART bit

Ports:
- clk  in  1  clock
- reset  in  1  reset
- wr  in  1  bus write enable
- reade  in  1  bus read enable
- addr  in  DM_ADDRESS  bus byte address
- wr_data  in  DATA_W  bus write data
- rd_data  out  DATA_W  read data, combinational
- hit  out  1  address falls in the window and (wr or reade) is high
- tx  out  1  UART serial output, registered
- irq_empty  out  1  registered; high when the FIFO is empty and the FSM is IDLE

Behaviour:
- Reset: reset is synchronous, active-high; clk is the clock. On reset:
  - tx=1, irq_empty=1
  - FIFO empty (pointers 0), overflow=0
  - div=DEFAULT_DIV, cycle=0, FSM=IDLE
  - rd_data=0 and hit=0 whenever the bus is idle.
  - Reset asserted mid-frame aborts the frame: tx=1 on the next edge and FIFO contents are discarded.
- Decode: sel = (addr[8:4]==BASE_HI). Offset = addr[3:2]; addr[1:0] is ignored. Accesses outside the window are ignored, and rd_data=0.
- Register map:
  - 0x0 TXDATA. Write pushes wr_data[7:0]. Read returns 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - Writing 1 to bit3 clears overflow; writing 0 has no effect.
  - 0x8 CYCLE. Read returns the current count. Write loads wr_data; the counter then continues incrementing from that value.
  - 0xC DIV. Bits[15:0] are read/write; upper bits read 0.
- Reads: rd_data is valid in the same cycle that reade and sel are high. The core registers it at the next edge.
- Write timing: a write takes effect at the edge that samples wr=1.
- Push to a full FIFO: the byte is dropped and overflow is set. "Full" is the value before the edge, even if a pop happens in the same cycle.
- Cycle counter: increments every clk and wraps 0xFFFFFFFF->0. A CYCLE write overrides the increment in that cycle.
- Divisor latching: div is latched into bitdiv at each frame start. A DIV write during a frame affects only the next frame. Latched value 0 is treated as 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head, load the shift register, set tx=0 and go to START.
  - Bit timing: each of START, each DATA bit and STOP holds tx for exactly bitdiv clocks, using a 16-bit down counter.
  - START->DATA: drive bit0.
  - DATA: 8 bits, LSB first, bit index 0..7. After bit7 go to STOP with tx=1.
  - STOP end: if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Frame length: 10*bitdiv clocks.
- Latency: TXDATA write sampled at edge E0 into an empty FIFO with the FSM idle. tx falls at edge E1.
- Simultaneous push and pop in the same cycle: both occur and the count is unchanged. A push into an empty FIFO is not visible to the FSM until the next cycle.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. Full/empty are derived from an extra wrap bit.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is sent between bit7 and STOP. It lasts bitdiv clocks.
  - Frame = 11*bitdiv clocks.
  - STATUS bit4 reads 1.
- Undefined: no parity state exists, the frame is 10*bitdiv clocks, and STATUS bit4 reads 0.

Test Plan:
- Reset then read 0x1F4 -> rd_data=0x2, hit=1, tx=1. Read 0x1FC -> 0x10. Read 0x100 -> hit=0, rd_data=0.
- DIV=4, write TXDATA 0x1F0 = 0xA5:
  - tx=0 from E1 for 4 clocks.
  - Then 1,0,1,0,0,1,0,1 at 4 clocks each, then stop 1.
  - busy drops 40 clocks after E1 and irq_empty=1.
- Back-to-back: with DIV=2, write 0x55 then 0x0F in consecutive cycles -> second start bit begins exactly 20 clocks after the first. No idle gap.
- Overflow: DIV=100, write 10 bytes -> FIFO holds 8 bytes (1 popped to the FSM), STATUS reads full=1 and overflow=1. Write 0x8 to STATUS -> overflow=0.
- Cycle counter: write CYCLE=0xFFFFFFFE; read 2 cycles later -> 0x00000000 (wrap).
- Reset mid-frame during DATA -> tx=1 next edge, STATUS=0x2, and no further bits are sent. With UART_PARITY_EN, 0x07 gives parity bit 1 and an 11-bit frame.

Source files
------------

// File: rtl/mmio_uart_responder.sv
// Memory-mapped UART TX peripheral: byte TX FIFO, serializer, baud divisor and a 32-bit cycle counter.
// Optional even-parity bit enabled by defining UART_PARITY_EN.
module mmio_uart_responder #(
  parameter int                  DATA_W      = 32,
  parameter int                  DM_ADDRESS  = 9,
  parameter logic [DM_ADDRESS-5:0] BASE_HI   = 5'h1F,
  parameter int                  FIFO_DEPTH  = 8,
  parameter logic [15:0]         DEFAULT_DIV = 16'd16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  reade,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  hit,
  output logic                  tx,
  output logic                  irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic PAR_EN = 1'b1;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic PAR_EN = 1'b0;
`endif

  state_t      state, state_n;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty, overflow;
  logic [15:0] div, bitdiv, cnt, div_eff;
  logic [31:0] cycle;
  logic [7:0]  shreg, head;
  logic [2:0]  bitidx;
  logic        par, tx_n, pop, bit_done;
  logic        sel, wr_tx, wr_st, wr_cy, wr_dv;
  logic [1:0]  off;
  logic        unused_bits;

  assign unused_bits = ^addr[1:0];

  assign sel   = (addr[DM_ADDRESS-1:4] == BASE_HI);
  assign off   = addr[3:2];
  assign hit   = sel & (wr | reade);
  assign wr_tx = wr & sel & (off == 2'd0);
  assign wr_st = wr & sel & (off == 2'd1);
  assign wr_cy = wr & sel & (off == 2'd2);
  assign wr_dv = wr & sel & (off == 2'd3);

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head     = mem[rptr[AW-1:0]];
  assign div_eff  = (div == '0) ? 16'd1 : div;
  assign bit_done = (cnt == '0);

  always_comb begin
    rd_data = '0;
    if (reade && sel) begin
      case (off)
        2'd1:    rd_data = DATA_W'({PAR_EN, overflow, (state != S_IDLE), empty, full});
        2'd2:    rd_data = DATA_W'(cycle);
        2'd3:    rd_data = DATA_W'(div);
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_tx && !full) mem[wptr[AW-1:0]] <= wr_data[7:0];
  end

  // Full is judged on the pre-edge pointers, so a same-cycle pop never rescues a push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_tx) begin
        if (full) overflow <= 1'b1;
        else      wptr     <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (wr_st && wr_data[3]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= DEFAULT_DIV;
      cycle <= '0;
    end else begin
      if (wr_dv) div <= wr_data[15:0];
      cycle <= wr_cy ? wr_data[31:0] : cycle + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!empty) state_n = S_START;
      S_START: if (bit_done) state_n = S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (bit_done && bitidx == 3'd7) state_n = S_PARITY;
      S_PARITY: if (bit_done) state_n = S_STOP;
`else
      S_DATA:  if (bit_done && bitidx == 3'd7) state_n = S_STOP;
`endif
      S_STOP:  if (bit_done) state_n = empty ? S_IDLE : S_START;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    tx_n = tx;
    case (state)
      S_IDLE:  if (!empty) begin pop = 1'b1; tx_n = 1'b0; end
      S_START: if (bit_done) tx_n = shreg[0];
      S_DATA:  if (bit_done) tx_n = (bitidx == 3'd7) ? (PAR_EN ? par : 1'b1) : shreg[1];
`ifdef UART_PARITY_EN
      S_PARITY: if (bit_done) tx_n = 1'b1;
`endif
      S_STOP:  if (bit_done && !empty) begin pop = 1'b1; tx_n = 1'b0; end
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx        <= 1'b1;
      irq_empty <= 1'b1;
      cnt       <= '0;
      bitdiv    <= 16'd1;
      bitidx    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
    end else begin
      tx        <= tx_n;
      irq_empty <= empty && (state == S_IDLE);
      if (pop) begin
        shreg  <= head;
        par    <= ^head;
        bitdiv <= div_eff;
        cnt    <= div_eff - 16'd1;
        bitidx <= '0;
      end else if (state != S_IDLE) begin
        if (bit_done) begin
          cnt <= bitdiv - 16'd1;
          if (state == S_DATA) begin
            bitidx <= bitidx + 3'd1;
            shreg  <= {1'b0, shreg[7:1]};
          end
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed self-checking bench for mmio_uart_responder; honours UART_PARITY_EN.
module tb_mmio_uart_responder;

  logic        clk, reset, wr, reade;
  logic [8:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        hit, tx, irq_empty;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

`ifdef UART_PARITY_EN
  localparam logic [31:0] PB = 32'h10;
`else
  localparam logic [31:0] PB = 32'h00;
`endif

  mmio_uart_responder #(.DATA_W(32), .DM_ADDRESS(9), .BASE_HI(5'h1F),
                        .FIFO_DEPTH(8), .DEFAULT_DIV(16'd16)) dut (
    .clk(clk), .reset(reset), .wr(wr), .reade(reade), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .hit(hit), .tx(tx), .irq_empty(irq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge samples the write.
  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [31:0] d, output logic h);
    addr = a; reade = 1'b1;
    #1;
    d = rd_data; h = hit;
    reade = 1'b0; addr = '0;
  endtask

  task automatic read_check(input string tag, input logic [8:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    bus_read(a, d, h);
    check({tag, "_data"}, d, exp);
    check({tag, "_hit"}, {31'b0, h}, {31'b0, a[8:4] == 5'h1F});
  endtask

  // Samples tx once per clock for one whole frame, starting now.
  task automatic check_frame(input logic [7:0] b, input int unsigned dv, input string tag);
    logic [10:0] fb;
    int unsigned nb;
`ifdef UART_PARITY_EN
    fb = {1'b1, ^b, b, 1'b0}; nb = 11;
`else
    fb = {1'b0, 1'b1, b, 1'b0}; nb = 10;
`endif
    for (int unsigned i = 0; i < nb; i++)
      for (int unsigned j = 0; j < dv; j++) begin
        check(tag, {31'b0, tx}, {31'b0, fb[i]});
        @(negedge clk);
      end
  endtask

  initial begin
    logic saw_low;
    reset = 1'b1; wr = 1'b0; reade = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq_empty}, 32'd1);
    check("idle_hit", {31'b0, hit}, 32'd0);
    read_check("rst_status", 9'h1F4, 32'h2 | PB);
    read_check("rst_div", 9'h1FC, 32'h10);
    read_check("rst_cycle", 9'h1F8, 32'h0);
    read_check("outside", 9'h100, 32'h0);
    read_check("txdata_rd", 9'h1F0, 32'h0);
    read_check("div_alias", 9'h1FE, 32'h10);

    bus_write(9'h10C, 32'h5);
    read_check("wr_outside", 9'h1FC, 32'h10);

    // Divisor 0 behaves as 1
    bus_write(9'h1FC, 32'hFFFF_0000);
    read_check("div_upper", 9'h1FC, 32'h0);
    bus_write(9'h1F0, 32'h07);
    @(negedge clk);
    check_frame(8'h07, 1, "frame_div0");
    read_check("div0_done", 9'h1F4, 32'h2 | PB);

    // Single frame at divisor 4
    bus_write(9'h1FC, 32'd4);
    bus_write(9'h1F0, 32'hA5);
    check("pre_start_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    read_check("busy_status", 9'h1F4, 32'h6 | PB);
    check("irq_busy", {31'b0, irq_empty}, 32'd0);
    check_frame(8'hA5, 4, "frame_a5");
    read_check("a5_done", 9'h1F4, 32'h2 | PB);
    @(negedge clk);
    check("irq_done", {31'b0, irq_empty}, 32'd1);

    // Back-to-back frames with no idle gap
    bus_write(9'h1FC, 32'd2);
    bus_write(9'h1F0, 32'h55);
    bus_write(9'h1F0, 32'h0F);
    check_frame(8'h55, 2, "b2b_first");
    check_frame(8'h0F, 2, "b2b_second");
    read_check("b2b_done", 9'h1F4, 32'h2 | PB);

    // Cycle counter wrap
    bus_write(9'h1F8, 32'hFFFF_FFFE);
    read_check("cyc_load", 9'h1F8, 32'hFFFF_FFFE);
    @(negedge clk);
    read_check("cyc_max", 9'h1F8, 32'hFFFF_FFFF);
    @(negedge clk);
    read_check("cyc_wrap", 9'h1F8, 32'h0);

    // Overflow: 1 popped, 8 queued, 1 dropped
    bus_write(9'h1FC, 32'd100);
    for (int unsigned i = 0; i < 10; i++) bus_write(9'h1F0, i);
    read_check("ovf_status", 9'h1F4, 32'hD | PB);
    bus_write(9'h1F4, 32'h0);
    read_check("ovf_keep", 9'h1F4, 32'hD | PB);
    bus_write(9'h1F4, 32'h8);
    read_check("ovf_clear", 9'h1F4, 32'h5 | PB);

    // Reset while byte 0x00 is in its DATA bits
    repeat (125) @(negedge clk);
    check("mid_data_tx", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx", {31'b0, tx}, 32'd1);
    check("abort_irq", {31'b0, irq_empty}, 32'd1);
    read_check("abort_status", 9'h1F4, 32'h2 | PB);
    read_check("abort_div", 9'h1FC, 32'h10);
    saw_low = 1'b0;
    repeat (1200) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("abort_quiet", {31'b0, saw_low}, 32'd0);
    read_check("abort_final", 9'h1F4, 32'h2 | PB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
